// File: rtl/spi_flash_reader_if.sv
// Request and byte-stream signals between user logic and the SPI flash reader.
// The user-logic side uses the master modport, the reader uses the slave modport.
`timescale 1ns/1ps
interface spi_flash_reader_if;
  logic        start;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;

  modport master (
    output start, addr, len, rd_ready,
    input  busy, done, rd_data, rd_valid
  );

  modport slave (
    input  start, addr, len, rd_ready,
    output busy, done, rd_data, rd_valid
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Single-bit SPI READ initiator returning flash bytes over a valid/ready stream.
// Define SPI_FLASH_READER_FAST_READ_EN to issue FAST_READ (0x0B) with 8 dummy SCK cycles.
`timescale 1ns/1ps
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  spi_flash_reader_if.slave  bus,
  output logic               flash_csb,
  output logic               flash_clk,
  output logic               flash_io0,
  input  logic               flash_io1
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  // One counter paces SCK phases while shifting and times the CS# high gap in END.
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] END_LAST = CW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef SPI_FLASH_READER_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_END
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   divCnt_q;
  logic            sck_q;
  logic            csb_q;
  logic            io0_q;
  logic [31:0]     txShift_q;
  logic [7:0]      rxShift_q;
  logic [4:0]      bitCnt_q;
  logic [7:0]      bytesLeft_q;
  logic            byteRdy_q;
  logic            rdValid_q;
  logic [7:0]      rdData_q;
  logic            busy_q;
  logic            done_q;

  logic            shifting;
  logic            phaseEnd;
  logic            handshake;
  logic            riseOk;
  logic            doRise;
  logic            doFall;
  logic [4:0]      phaseBits;
  logic            phaseDone;

  assign shifting  = (state_q != S_IDLE) && (state_q != S_END);
  assign phaseEnd  = (divCnt_q == DIV_LAST);
  assign handshake = rdValid_q && bus.rd_ready;
  assign doRise    = shifting && phaseEnd && !sck_q && riseOk;
  assign doFall    = shifting && phaseEnd && sck_q;
  assign phaseDone = (bitCnt_q == phaseBits);

  // A new byte may not start clocking while the previous one is still unclaimed,
  // so SCK simply parks low until the consumer takes it.
  always_comb begin
    riseOk = 1'b1;
    if (state_q == S_DATA) begin
      riseOk = (bytesLeft_q != 8'd0) && !byteRdy_q && !(rdValid_q && !bus.rd_ready);
    end
  end

  always_comb begin
    phaseBits = 5'd8;
    if (state_q == S_ADDR) begin
      phaseBits = 5'd24;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      divCnt_q    <= '0;
      sck_q       <= 1'b0;
      csb_q       <= 1'b1;
      io0_q       <= 1'b0;
      txShift_q   <= '0;
      rxShift_q   <= '0;
      bitCnt_q    <= '0;
      bytesLeft_q <= '0;
      byteRdy_q   <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= S_CMD;
              busy_q      <= 1'b1;
              csb_q       <= 1'b0;
              io0_q       <= CMD_BYTE[7];
              txShift_q   <= {CMD_BYTE, bus.addr};
              bytesLeft_q <= bus.len;
              divCnt_q    <= '0;
              sck_q       <= 1'b0;
              bitCnt_q    <= '0;
            end
          end
        end

        S_END: begin
          if (divCnt_q == END_LAST) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            divCnt_q <= '0;
          end else begin
            divCnt_q <= divCnt_q + CW'(1);
          end
        end

        default: begin
          if (doRise || doFall) begin
            divCnt_q <= '0;
          end else if (!phaseEnd) begin
            divCnt_q <= divCnt_q + CW'(1);
          end

          if (doRise) begin
            sck_q     <= 1'b1;
            rxShift_q <= {rxShift_q[6:0], flash_io1};
            bitCnt_q  <= bitCnt_q + 5'd1;
          end

          // Zeros shift in behind the address, so io0 idles low through dummy and data.
          if (doFall) begin
            sck_q     <= 1'b0;
            io0_q     <= txShift_q[30];
            txShift_q <= {txShift_q[30:0], 1'b0};
            if (phaseDone) begin
              bitCnt_q <= '0;
              case (state_q)
                S_CMD:  state_q <= S_ADDR;
`ifdef SPI_FLASH_READER_FAST_READ_EN
                S_ADDR:  state_q <= S_DUMMY;
                S_DUMMY: state_q <= S_DATA;
`else
                S_ADDR: state_q <= S_DATA;
`endif
                S_DATA: begin
                  rdData_q    <= rxShift_q;
                  byteRdy_q   <= 1'b1;
                  bytesLeft_q <= bytesLeft_q - 8'd1;
                end
                default: state_q <= state_q;
              endcase
            end
          end

          if (byteRdy_q) begin
            rdValid_q <= 1'b1;
            byteRdy_q <= 1'b0;
          end

          if (handshake) begin
            rdValid_q <= 1'b0;
            if (bytesLeft_q == 8'd0) begin
              state_q  <= S_END;
              csb_q    <= 1'b1;
              divCnt_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign flash_csb    = csb_q;
  assign flash_clk    = sck_q;
  assign flash_io0    = io0_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_data  = rdData_q;
  assign bus.rd_valid = rdValid_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a behavioural SPI flash answering READ/FAST_READ.
// Expected bytes are queued at request time and popped on each stream handshake.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  localparam int CLK_DIV = 2;
`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] EXP_CMD  = 8'h0B;
  localparam int         HDR_BITS = 40;
  localparam int         EXTRA    = 16 * CLK_DIV;
`else
  localparam logic [7:0] EXP_CMD  = 8'h03;
  localparam int         HDR_BITS = 32;
  localparam int         EXTRA    = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_flash_reader_if bus();
  logic flash_csb;
  logic flash_clk;
  logic flash_io0;
  logic flash_io1 = 1'b0;

  spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .flash_csb(flash_csb),
    .flash_clk(flash_clk),
    .flash_io0(flash_io0),
    .flash_io1(flash_io1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbQ[$];
  int         hsCycles[$];
  int         cycCnt = 0;
  int         doneCount = 0;
  int         busyCount = 0;
  int         csbLowCount = 0;
  int         riseCount = 0;
  int         firstValidCyc = -1;
  int         lastDoneCyc = 0;
  int         startCyc = 0;

  int          fRise = 0;
  logic [31:0] fSh = '0;
  int          fIdx;
  logic [7:0]  fByte;
  logic [7:0]  expByte;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flashByte(input logic [23:0] a);
    logic [31:0] p;
    p = {8'd0, a} * 32'd17;
    return p[7:0];
  endfunction

  // Flash model: captures command/address on rising SCK, shifts data out on falling SCK.
  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fRise = 0;
    end else begin
      if (fRise < 32) fSh = {fSh[30:0], flash_io0};
      fRise++;
    end
  end

  always @(negedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      flash_io1 = 1'b0;
    end else if (fRise >= HDR_BITS) begin
      fIdx      = fRise - HDR_BITS;
      fByte     = flashByte(fSh[23:0] + 24'(fIdx / 8));
      flash_io1 = fByte[3'(7 - fIdx % 8)];
    end
  end

  always @(posedge flash_clk) riseCount++;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Stream monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        doneCount++;
        lastDoneCyc = cycCnt;
      end
      if (bus.busy) busyCount++;
      if (!flash_csb) csbLowCount++;
      if (bus.rd_valid && firstValidCyc < 0) firstValidCyc = cycCnt;
      if (bus.rd_valid && bus.rd_ready) begin
        hsCycles.push_back(cycCnt);
        if (sbQ.size() == 0) begin
          checkOutput("sb_nonempty", 32'(sbQ.size()), 32'd1);
        end else begin
          expByte = sbQ.pop_front();
          checkOutput("rd_data", {24'd0, bus.rd_data}, {24'd0, expByte});
        end
      end
    end
  end

  task automatic clearCounters();
    doneCount     = 0;
    busyCount     = 0;
    csbLowCount   = 0;
    riseCount     = 0;
    firstValidCyc = -1;
    hsCycles.delete();
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic [7:0] l);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.addr  = a;
    bus.len   = l;
    for (int i = 0; i < int'(l); i++) sbQ.push_back(flashByte(a + 24'(i)));
    @(posedge clk);
    #1;
    startCyc  = cycCnt - 1;
    bus.start = 1'b0;
    bus.addr  = 24'hFFFFFF;
    bus.len   = 8'hAA;
  endtask

  task automatic waitDone(input int maxCyc);
    int n;
    int d0;
    n  = 0;
    d0 = doneCount;
    while (doneCount == d0 && n < maxCyc) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(doneCount != d0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int maxCyc);
    int n;
    n = 0;
    while (!bus.rd_valid && n < maxCyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("valid_seen", 32'(bus.rd_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int r0;
    int c0;
    bus.start    = 1'b0;
    bus.addr     = '0;
    bus.len      = '0;
    bus.rd_ready = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_csb", 32'(flash_csb), 32'd1);
    checkOutput("rst_sck", 32'(flash_clk), 32'd0);
    checkOutput("rst_io0", 32'(flash_io0), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b0;

    $display("[TB] streaming read, addr 0, len 4, ready high");
    bus.rd_ready = 1'b1;
    clearCounters();
    applyStimulus(24'h000000, 8'd4);
    checkOutput("t1_csb_cycle1", 32'(flash_csb), 32'd0);
    checkOutput("t1_io0_cycle1", 32'(flash_io0), 32'(EXP_CMD[7]));
    checkOutput("t1_busy_cycle1", 32'(bus.busy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.addr  = 24'h000055;
    bus.len   = 8'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(2000);
    checkOutput("t1_latency", 32'(firstValidCyc - startCyc), 32'(162 + EXTRA));
    checkOutput("t1_bytes", 32'(hsCycles.size()), 32'd4);
    if (hsCycles.size() == 4) begin
      for (int i = 1; i < 4; i++)
        checkOutput("t1_spacing", 32'(hsCycles[i] - hsCycles[i-1]), 32'(16 * CLK_DIV));
      checkOutput("t1_done_delay", 32'(lastDoneCyc - hsCycles[3]), 32'(2 * CLK_DIV + 1));
    end
    checkOutput("t1_done_count", 32'(doneCount), 32'd1);
    checkOutput("t1_cmd", {24'd0, fSh[31:24]}, {24'd0, EXP_CMD});
    checkOutput("t1_addr", {8'd0, fSh[23:0]}, 32'h000000);
    checkOutput("t1_sb_drain", 32'(sbQ.size()), 32'd0);
    checkOutput("t1_idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] single byte at 0x000102");
    clearCounters();
    applyStimulus(24'h000102, 8'd1);
    waitDone(2000);
    checkOutput("t2_cmd", {24'd0, fSh[31:24]}, {24'd0, EXP_CMD});
    checkOutput("t2_addr", {8'd0, fSh[23:0]}, 32'h000102);
    checkOutput("t2_bytes", 32'(hsCycles.size()), 32'd1);
    checkOutput("t2_sb_drain", 32'(sbQ.size()), 32'd0);

    $display("[TB] back-pressure, len 3, 50-cycle stalls");
    bus.rd_ready = 1'b0;
    clearCounters();
    applyStimulus(24'h000040, 8'd3);
    for (int b = 0; b < 3; b++) begin
      waitValid(1000);
      r0 = riseCount;
      c0 = csbLowCount;
      repeat (50) @(posedge clk);
      #1;
      checkOutput("t3_sck_frozen", 32'(riseCount - r0), 32'd0);
      checkOutput("t3_csb_held", 32'(csbLowCount - c0), 32'd50);
      checkOutput("t3_valid_held", 32'(bus.rd_valid), 32'd1);
      bus.rd_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_ready = 1'b0;
    end
    waitDone(2000);
    checkOutput("t3_bytes", 32'(hsCycles.size()), 32'd3);
    checkOutput("t3_sb_drain", 32'(sbQ.size()), 32'd0);

    $display("[TB] zero-length request");
    clearCounters();
    applyStimulus(24'h000123, 8'd0);
    checkOutput("t4_done_cycle1", 32'(bus.done), 32'd1);
    checkOutput("t4_busy_cycle1", 32'(bus.busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t4_no_sck", 32'(riseCount), 32'd0);
    checkOutput("t4_no_csb", 32'(csbLowCount), 32'd0);
    checkOutput("t4_no_busy", 32'(busyCount), 32'd0);
    checkOutput("t4_done_count", 32'(doneCount), 32'd1);

    $display("[TB] reset during address phase, then fresh read");
    bus.rd_ready = 1'b1;
    clearCounters();
    applyStimulus(24'h000000, 8'd2);
    repeat (58) @(posedge clk);
    #1;
    checkOutput("t5_sck_before_rst", 32'(flash_clk), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_csb", 32'(flash_csb), 32'd1);
    checkOutput("t5_rst_sck", 32'(flash_clk), 32'd0);
    checkOutput("t5_rst_busy", 32'(bus.busy), 32'd0);
    sbQ.delete();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    clearCounters();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5_no_done", 32'(doneCount), 32'd0);
    checkOutput("t5_no_valid", 32'(bus.rd_valid), 32'd0);
    applyStimulus(24'h0000A0, 8'd2);
    waitDone(2000);
    checkOutput("t5_cmd", {24'd0, fSh[31:24]}, {24'd0, EXP_CMD});
    checkOutput("t5_bytes", 32'(hsCycles.size()), 32'd2);
    checkOutput("t5_sb_drain", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
